interrupt_sequencer: RTL and testbench

Sequences hardware interrupt entry for the pipelined CPU. Captures an external interrupt request, waits until the instruction in decode is safe to interrupt, then runs a fixed sequence: flush decode, hold the decode-stage interrupt input for the PC-push cycles, and load the vector address into the PC. It sits beside fetch/decode, driving decode's `i_interrupt` and the fetch PC-load/stall controls. It masks further entries until a return-from-interrupt retires.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/interrupt_sequencer.sv | 129 ++++++++++++
 tb/tb_interrupt_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the interrupt entry logic.
//   PC_W            : program counter width
//   INT_VECTOR_ADDR : default PC loaded on hardware interrupt entry
//   int_state_t     : interrupt sequencer FSM state encoding
package cpu_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] INT_VECTOR_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SAFE = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_PUSH      = 3'd3,
    ST_VECTOR    = 3'd4
  } int_state_t;

endpackage

// File: rtl/interrupt_sequencer.sv
// Hardware interrupt entry sequencer for the pipelined CPU.
// Latches an interrupt request, waits until the decode instruction can be
// split, then flushes decode, holds decode's push-PC control for
// PUSH_CYCLES cycles and loads the vector address into the PC. Further
// entries are masked until a return-from-interrupt retires.
//
// Ports:
//   i_clk, i_reset         clock (rising edge), asynchronous active-low reset
//   i_int_req              interrupt request (pulse or level)
//   i_hazard_instruction   decode instruction must not be split
//   i_stall                pipeline stalled by the hazard unit
//   i_rti                  return-from-interrupt retiring (1-cycle pulse)
//   i_fetch_pc             PC of the next instruction to resume at
//   o_int_active           decode i_interrupt (push-PC control)
//   o_stall_fetch          freeze the PC/fetch register
//   o_flush_decode         bubble the fetch/decode register
//   o_pc_load, o_pc_value  PC load strobe and value (value 0 when not loading)
//   o_return_pc            saved resume PC
//   o_in_isr               interrupt service in progress (entries masked)
//   o_busy                 FSM not idle
module interrupt_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] VECTOR_ADDR = INT_VECTOR_ADDR,
  parameter int              PUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_int_req,
  input  logic            i_hazard_instruction,
  input  logic            i_stall,
  input  logic            i_rti,
  input  logic [PC_W-1:0] i_fetch_pc,
  output logic            o_int_active,
  output logic            o_stall_fetch,
  output logic            o_flush_decode,
  output logic            o_pc_load,
  output logic [PC_W-1:0] o_pc_value,
  output logic [PC_W-1:0] o_return_pc,
  output logic            o_in_isr,
  output logic            o_busy
);

  localparam logic [2:0] PUSH_LAST = 3'(PUSH_CYCLES - 1);

  int_state_t      state;
  logic            pending;
  logic [2:0]      push_cnt;
  logic            in_isr;
  logic [PC_W-1:0] return_pc;

  logic safe;
  logic unmasked;

  assign safe = !i_hazard_instruction && !i_stall;
  // An RTI retiring this cycle lifts the mask early enough that a
  // still-pending request can reach FLUSH on the very next cycle.
  assign unmasked = !in_isr || i_rti;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      pending   <= 1'b0;
      push_cnt  <= 3'd0;
      in_isr    <= 1'b0;
      return_pc <= '0;
    end else begin
      // A new request in the VECTOR cycle must survive the clear.
      if (i_int_req)
        pending <= 1'b1;
      else if (state == ST_VECTOR)
        pending <= 1'b0;

      if (state == ST_VECTOR)
        in_isr <= 1'b1;
      else if (i_rti)
        in_isr <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pending && unmasked) begin
            if (safe) begin
              state     <= ST_FLUSH;
              return_pc <= i_fetch_pc;
            end else begin
              state <= ST_WAIT_SAFE;
            end
          end
        end
        ST_WAIT_SAFE: begin
          if (safe) begin
            state     <= ST_FLUSH;
            return_pc <= i_fetch_pc;
          end
        end
        ST_FLUSH: begin
          state    <= ST_PUSH;
          push_cnt <= 3'd0;
        end
        ST_PUSH: begin
          if (push_cnt == PUSH_LAST) begin
            state    <= ST_VECTOR;
            push_cnt <= 3'd0;
          end else begin
            push_cnt <= push_cnt + 3'd1;
          end
        end
        ST_VECTOR: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          push_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Moore outputs decoded from the registered state
  assign o_flush_decode = (state == ST_FLUSH);
  assign o_int_active   = (state == ST_PUSH);
  assign o_stall_fetch  = (state == ST_FLUSH) || (state == ST_PUSH);
  assign o_pc_load      = (state == ST_VECTOR);
  assign o_pc_value     = (state == ST_VECTOR) ? VECTOR_ADDR : '0;
  assign o_busy         = (state != ST_IDLE);
  assign o_return_pc    = return_pc;
  assign o_in_isr       = in_isr;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Testbench for interrupt_sequencer. Expected FLUSH/PUSH/VECTOR cycles are
// queued as stimulus is issued; a monitor pops one entry each cycle the
// sequencer presents flush, push or PC-load activity and compares it.
module tb_interrupt_sequencer;

  logic        clk;
  logic        rst_n;
  logic        int_req;
  logic        hazard;
  logic        stall;
  logic        rti;
  logic [31:0] fetch_pc;
  logic        int_active;
  logic        stall_fetch;
  logic        flush_decode;
  logic        pc_load;
  logic [31:0] pc_value;
  logic [31:0] return_pc;
  logic        in_isr;
  logic        busy;

  int checks;
  int failures;
  int cyc;

  // kind = {busy, flush, int_active, pc_load, stall_fetch}
  localparam logic [4:0] K_FLUSH  = 5'b11001;
  localparam logic [4:0] K_PUSH   = 5'b10101;
  localparam logic [4:0] K_VECTOR = 5'b10010;

  typedef struct {
    int          at;
    logic [4:0]  kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  interrupt_sequencer dut (
    .i_clk                (clk),
    .i_reset              (rst_n),
    .i_int_req            (int_req),
    .i_hazard_instruction (hazard),
    .i_stall              (stall),
    .i_rti                (rti),
    .i_fetch_pc           (fetch_pc),
    .o_int_active         (int_active),
    .o_stall_fetch        (stall_fetch),
    .o_flush_decode       (flush_decode),
    .o_pc_load            (pc_load),
    .o_pc_value           (pc_value),
    .o_return_pc          (return_pc),
    .o_in_isr             (in_isr),
    .o_busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full entry: FLUSH at cycle f, two PUSH cycles, VECTOR loading 0.
  task automatic expect_entry(input int f, input logic [31:0] rpc);
    exp_q.push_back('{at: f,     kind: K_FLUSH,  val: rpc});
    exp_q.push_back('{at: f + 1, kind: K_PUSH,   val: 32'h0});
    exp_q.push_back('{at: f + 2, kind: K_PUSH,   val: 32'h0});
    exp_q.push_back('{at: f + 3, kind: K_VECTOR, val: 32'h0});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_int_active"},   {31'b0, int_active},   32'h0);
    chk({tag, "_stall_fetch"},  {31'b0, stall_fetch},  32'h0);
    chk({tag, "_flush_decode"}, {31'b0, flush_decode}, 32'h0);
    chk({tag, "_pc_load"},      {31'b0, pc_load},      32'h0);
    chk({tag, "_pc_value"},     pc_value,              32'h0);
    chk({tag, "_return_pc"},    return_pc,             32'h0);
    chk({tag, "_in_isr"},       {31'b0, in_isr},       32'h0);
    chk({tag, "_busy"},         {31'b0, busy},         32'h0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (!pc_load)
        chk("pc_value_when_idle", pc_value, 32'h0);
      if (flush_decode || int_active || pc_load) begin
        logic [4:0]  obs_kind;
        logic [31:0] obs_val;
        exp_t        e;
        obs_kind = {busy, flush_decode, int_active, pc_load, stall_fetch};
        obs_val  = pc_load ? pc_value : (flush_decode ? return_pc : 32'h0);
        if (exp_q.size() == 0) begin
          chk("unexpected_activity", {27'b0, obs_kind}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", cyc,                 e.at);
          chk("event_kind",  {27'b0, obs_kind},   {27'b0, e.kind});
          chk("event_value", obs_val,             e.val);
        end
      end
    end
  end

  initial begin
    int t0;
    int r;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    int_req  = 1'b0;
    hazard   = 1'b0;
    stall    = 1'b0;
    rti      = 1'b0;
    fetch_pc = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Stray RTI while idle and unmasked
    rti = 1'b1;
    tick();
    rti = 1'b0;
    tick();
    chk("stray_rti_in_isr", {31'b0, in_isr}, 32'h0);
    chk("stray_rti_busy",   {31'b0, busy},   32'h0);

    // Basic entry
    t0       = cyc;
    fetch_pc = 32'h0000_0040;
    int_req  = 1'b1;
    expect_entry(t0 + 2, 32'h40);
    tick();
    int_req = 1'b0;
    repeat (4) tick();
    chk("basic_in_isr_in_vector", {31'b0, in_isr}, 32'h0);
    tick();
    chk("basic_in_isr_after", {31'b0, in_isr},  32'h1);
    chk("basic_return_pc",    return_pc,        32'h40);
    chk("basic_busy_after",   {31'b0, busy},    32'h0);

    // Masking: request during ISR waits for RTI
    int_req  = 1'b1;
    fetch_pc = 32'h0000_0100;
    tick();
    int_req = 1'b0;
    repeat (4) tick();
    chk("mask_busy_held_off", {31'b0, busy},   32'h0);
    chk("mask_in_isr_held",   {31'b0, in_isr}, 32'h1);
    r   = cyc;
    rti = 1'b1;
    expect_entry(r + 1, 32'h100);
    tick();
    rti = 1'b0;
    chk("mask_in_isr_cleared", {31'b0, in_isr}, 32'h0);
    repeat (4) tick();
    chk("mask_in_isr_again", {31'b0, in_isr}, 32'h1);

    // Set/clear collision on the VECTOR cycle
    rti = 1'b1;
    tick();
    rti = 1'b0;
    tick();
    t0       = cyc;
    fetch_pc = 32'h0000_0200;
    int_req  = 1'b1;
    expect_entry(t0 + 2, 32'h200);
    tick();
    int_req = 1'b0;
    repeat (4) tick();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    chk("collide_in_isr", {31'b0, in_isr}, 32'h1);
    repeat (3) tick();
    chk("collide_masked_busy", {31'b0, busy}, 32'h0);
    fetch_pc = 32'h0000_0300;
    r   = cyc;
    rti = 1'b1;
    expect_entry(r + 1, 32'h300);
    tick();
    rti = 1'b0;
    repeat (4) tick();
    chk("collide_serviced_in_isr", {31'b0, in_isr},  32'h1);
    chk("collide_return_pc",       return_pc,        32'h300);
    rti = 1'b1;
    tick();
    rti = 1'b0;
    tick();

    // Hazard hold-off: three unsafe cycles push FLUSH from 2 to 5
    t0       = cyc;
    fetch_pc = 32'h0000_0400;
    int_req  = 1'b1;
    expect_entry(t0 + 5, 32'h400);
    tick();
    int_req = 1'b0;
    hazard  = 1'b1;
    tick();
    chk("wait_busy",        {31'b0, busy},        32'h1);
    chk("wait_stall_fetch", {31'b0, stall_fetch}, 32'h0);
    tick();
    chk("wait_stall_fetch2", {31'b0, stall_fetch}, 32'h0);
    tick();
    hazard = 1'b0;
    chk("wait_stall_fetch3", {31'b0, stall_fetch}, 32'h0);
    chk("wait_busy3",        {31'b0, busy},        32'h1);
    tick();
    tick();
    // Hazard and stall during PUSH must not abort the sequence
    hazard = 1'b1;
    stall  = 1'b1;
    tick();
    hazard = 1'b0;
    stall  = 1'b0;
    tick();
    tick();
    chk("hazard_in_isr", {31'b0, in_isr}, 32'h1);
    rti = 1'b1;
    tick();
    rti = 1'b0;
    tick();

    // Reset during the first PUSH cycle
    t0       = cyc;
    fetch_pc = 32'h0000_0500;
    int_req  = 1'b1;
    exp_q.push_back('{at: t0 + 2, kind: K_FLUSH, val: 32'h500});
    exp_q.push_back('{at: t0 + 3, kind: K_PUSH,  val: 32'h0});
    tick();
    int_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) tick();
    chk("post_reset_busy",   {31'b0, busy},   32'h0);
    chk("post_reset_in_isr", {31'b0, in_isr}, 32'h0);

    chk("expected_queue_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
